csr_unit: RTL

//  Machine-mode CSR file and trap controller for the memory/writeback stage of the 3-stage pipeline.

---
 rtl/csr_pkg.sv | 31 +++
 rtl/csr_cycle_counter.sv | 38 +++
 rtl/csr_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, trap cause codes,
// the CSR operation encoding and the bit positions of the architected fields.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;
   localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;
   localparam int MIE_MTIE       = 7;
   localparam int MIE_MEIE       = 11;

endpackage

// File: rtl/csr_cycle_counter.sv
// Free-running 64-bit cycle counter; a software write replaces one half and
// suppresses the increment for that cycle.
module csr_cycle_counter
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_lo_i,
   input  logic              wr_hi_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic [2*XLEN-1:0] count_o
);

   logic [2*XLEN-1:0] count_q;
   logic [2*XLEN-1:0] count_d;

   always_comb begin
      count_d = count_q + {{(2*XLEN-1){1'b0}}, 1'b1};
      if (wr_lo_i) begin
         count_d = {count_q[2*XLEN-1:XLEN], wdata_i};
      end else if (wr_hi_i) begin
         count_d = {wdata_i, count_q[XLEN-1:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller for the MW stage: CSR read/modify/write,
// timer/external interrupt entry, mret, and the PC redirect that flushes younger stages.
module csr_unit
   import csr_pkg::*;
#(
   parameter int                XLEN        = 32,
   parameter logic [XLEN-1:0]   RESET_MTVEC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            csr_reg_rdpin_MW,
   input  logic            csr_reg_wrpin_MW,
   input  logic            is_mret_MW,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic [XLEN-1:0] pc_MW,
   input  logic            timer_irq,
   input  logic            ext_irq,
   output logic [XLEN-1:0] csr_rdata,
   output logic            epc_taken,
   output logic [XLEN-1:0] epc_evec
);

   localparam logic [XLEN-1:0] ALIGN4 = ~(XLEN'(3));

   logic            mstatus_mie_q;
   logic            mstatus_mpie_q;
   logic            mie_mtie_q;
   logic            mie_meie_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic [2*XLEN-1:0] mcycle;

   csr_op_e         op;
   logic [XLEN-1:0] mstatus_val;
   logic [XLEN-1:0] mie_val;
   logic [XLEN-1:0] mip_val;
   logic [XLEN-1:0] csr_old;
   logic [XLEN-1:0] csr_new;
   logic [XLEN-1:0] trap_base;
   logic            irq_ext;
   logic            irq_tim;
   logic            irq_take;
   logic            mret_take;
   logic            csr_we;
   logic [3:0]      cause;

   // Read mux, write-value computation, interrupt arbitration and redirect target.
   always_comb begin
      op          = csr_op_e'(csr_op);
      mstatus_val = '0;
      mie_val     = '0;
      mip_val     = '0;
      mstatus_val[MSTATUS_MIE]  = mstatus_mie_q;
      mstatus_val[MSTATUS_MPIE] = mstatus_mpie_q;
      mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mie_val[MIE_MTIE] = mie_mtie_q;
      mie_val[MIE_MEIE] = mie_meie_q;
      mip_val[MIE_MTIE] = timer_irq;
      mip_val[MIE_MEIE] = ext_irq;

      case (csr_addr)
         CSR_MSTATUS: csr_old = mstatus_val;
         CSR_MIE:     csr_old = mie_val;
         CSR_MTVEC:   csr_old = mtvec_q;
         CSR_MEPC:    csr_old = mepc_q;
         CSR_MCAUSE:  csr_old = mcause_q;
         CSR_MIP:     csr_old = mip_val;
         CSR_MCYCLE:  csr_old = mcycle[XLEN-1:0];
         CSR_MCYCLEH: csr_old = mcycle[2*XLEN-1:XLEN];
         default:     csr_old = '0;
      endcase

      case (op)
         CSR_OP_RW: csr_new = csr_wdata;
         CSR_OP_RS: csr_new = csr_old | csr_wdata;
         CSR_OP_RC: csr_new = csr_old & ~csr_wdata;
         default:   csr_new = csr_old;
      endcase

      irq_ext   = mie_meie_q & ext_irq;
      irq_tim   = mie_mtie_q & timer_irq;
      irq_take  = en & mstatus_mie_q & (irq_ext | irq_tim);
      cause     = irq_ext ? CAUSE_MEI : CAUSE_MTI;
      mret_take = en & is_mret_MW & ~irq_take;
      csr_we    = en & csr_reg_wrpin_MW & ~irq_take & (op != CSR_OP_NONE);
      trap_base = {mtvec_q[XLEN-1:2], 2'b00};

      csr_rdata = '0;
      epc_taken = 1'b0;
      epc_evec  = '0;
      if (!rst) begin
         if (csr_reg_rdpin_MW) begin
            csr_rdata = csr_old;
         end
         if (irq_take) begin
            epc_taken = 1'b1;
            epc_evec  = mtvec_q[0] ? trap_base + XLEN'({cause, 2'b00}) : trap_base;
         end else if (mret_take) begin
            epc_taken = 1'b1;
            epc_evec  = mepc_q;
         end
      end
   end

   csr_cycle_counter #(.XLEN(XLEN)) u_cycle (
      .clk     (clk),
      .rst     (rst),
      .wr_lo_i (csr_we && (csr_addr == CSR_MCYCLE)),
      .wr_hi_i (csr_we && (csr_addr == CSR_MCYCLEH)),
      .wdata_i (csr_new),
      .count_o (mcycle)
   );

   // A taken interrupt kills the MW instruction entirely; otherwise the CSR write
   // lands first and mret then overrides mstatus, so mret always wins that field.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_mtie_q     <= 1'b0;
         mie_meie_q     <= 1'b0;
         mtvec_q        <= RESET_MTVEC;
         mepc_q         <= '0;
         mcause_q       <= '0;
      end else if (irq_take) begin
         mepc_q         <= pc_MW & ALIGN4;
         mcause_q       <= {1'b1, {(XLEN-5){1'b0}}, cause};
         mstatus_mpie_q <= mstatus_mie_q;
         mstatus_mie_q  <= 1'b0;
      end else begin
         if (csr_we) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  if (!mret_take) begin
                     mstatus_mie_q  <= csr_new[MSTATUS_MIE];
                     mstatus_mpie_q <= csr_new[MSTATUS_MPIE];
                  end
               end
               CSR_MIE: begin
                  mie_mtie_q <= csr_new[MIE_MTIE];
                  mie_meie_q <= csr_new[MIE_MEIE];
               end
               CSR_MTVEC:  mtvec_q  <= {csr_new[XLEN-1:2], 1'b0, csr_new[0]};
               CSR_MEPC:   mepc_q   <= csr_new & ALIGN4;
               CSR_MCAUSE: mcause_q <= csr_new;
               default: ;
            endcase
         end
         if (mret_take) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
         end
      end
   end

endmodule
